trainer_sweep_ctrl: RTL
=======================

TRAINER_SWEEP_CTRL -- requirements
Module: trainer_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 8, meaning cycles each input vector is held before capture; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ena  input  1  clock enable; low freezes all state.
REQ-005 SHALL have port mode  input  1  0 = manual, 1 = auto sweep.
REQ-006 SHALL have port start  input  1  sweep request, sampled per cycle.
REQ-007 SHALL have port man_a, man_b  input  1 each  manual A/B operands.
REQ-008 SHALL have port rd_row  input  2  captured-row readout select.
REQ-009 SHALL have port live_out  output  7  current gate-bank outputs, bit0..6 = AND, OR, NOTA, NAND, NOR, XOR, XNOR.
REQ-010 SHALL have port row_out  output  7  captured row rd_row, same bit order.
REQ-011 SHALL have port step  output  2  index of vector being applied.
REQ-012 SHALL have ports busy, done, pass, fail  output  1 each  sweep status.

Function
REQ-013 SHALL apply gate-bank operands A = man_a, B = man_b combinationally when mode=0 or state is IDLE.
REQ-014 SHALL implement FSM IDLE -> APPLY -> DONE, where APPLY carries a 2-bit row index and an 8-bit dwell counter.
REQ-015 SHALL leave IDLE or DONE for APPLY (index 0, counter 0) on an edge where ena=1, mode=1 and start=1; it SHALL clear done, pass, fail and all captured rows on that edge.
REQ-016 SHALL drive, in APPLY, A = index[0] and B = index[1], with step = index.
REQ-017 SHALL hold each vector exactly DWELL cycles and SHALL capture live_out into row[index] on the closing edge of the DWELL-th cycle.
REQ-018 SHALL increment index after capturing rows 0..2; after capturing row 3 it SHALL enter DONE, making start-edge-to-done latency exactly 4*DWELL cycles.
REQ-019 SHALL assert busy only in APPLY; done SHALL be a level that is high in DONE until the next accepted start or abort.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL abort to IDLE when mode=0 during APPLY, clearing rows, done, pass and fail on that edge.
REQ-022 SHALL, when ena=0, hold state, counter, index and rows unchanged; live_out SHALL remain combinational.
REQ-023 SHALL make row_out a combinational mux of row[rd_row]; uncaptured rows SHALL read 0.

Reset
REQ-024 SHALL, on rst_n low, immediately force state=IDLE, index=0, counter=0, rows=0, busy=0, done=0, pass=0 and fail=0, including mid-sweep.
REQ-025 SHALL make step=0 and row_out=0 after reset; live_out SHALL follow man_a/man_b.

Configuration
REQ-026 SHALL, with TRAINER_SELFTEST_EN defined, register pass=1 or fail=1 on the DONE-entry edge by comparing rows 0..3 against 0x5C, 0x2A, 0x2E, 0x43 (pass iff all four match, fail otherwise).
REQ-027 SHALL, without TRAINER_SELFTEST_EN, tie pass and fail to 0 and synthesize no comparator.

Structure
REQ-028 SHALL place the gate bit-index constants, the expected-row constants and the FSM state enum in shared package trainer_pkg.
REQ-029 SHALL instantiate a single combinational sub-module trainer_gate_bank (A, B -> 7-bit y) driving live_out.

Verification
REQ-030 SHALL cover manual mode: mode=0 with (man_a, man_b) = 00, 10, 01, 11 -> live_out = 0x5C, 0x2A, 0x2E, 0x43.
REQ-031 SHALL cover a full sweep: DWELL=8, one-cycle start with mode=1 -> busy for 32 cycles, step 0,1,2,3 for 8 cycles each, done=1 at cycle 32, rd_row 0..3 -> 0x5C, 0x2A, 0x2E, 0x43, pass=1 and fail=0 with TRAINER_SELFTEST_EN.
REQ-032 SHALL cover fault detection: force gate-bank y[5]=0 during the sweep -> row 1 = 0x0A, fail=1, pass=0.
REQ-033 SHALL cover start while busy: start pulse at cycle 10 -> ignored, done still at cycle 32.
REQ-034 SHALL cover abort: mode->0 at cycle 12 -> busy=0 next edge, rows read 0, done=0; rst_n pulse at cycle 20 of a new sweep -> all outputs at reset values immediately.
REQ-035 SHALL cover ena freeze: ena=0 for 5 cycles mid-sweep -> done delayed to cycle 37, captured rows unchanged.

Source files
------------

// File: rtl/trainer_pkg.sv
// Shared constants for the logic-gate trainer: gate bit positions, the
// reference truth-table rows and the sweep FSM state encoding.
package trainer_pkg;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    // Gate-bank output for (A,B) = 00, 10, 01, 11, i.e. row index = {B,A}
    localparam logic [6:0] EXP_ROW0 = 7'h5C;
    localparam logic [6:0] EXP_ROW1 = 7'h2A;
    localparam logic [6:0] EXP_ROW2 = 7'h2E;
    localparam logic [6:0] EXP_ROW3 = 7'h43;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    function automatic logic rows_match(
        input logic [6:0] r0,
        input logic [6:0] r1,
        input logic [6:0] r2,
        input logic [6:0] r3
    );
        return (r0 == EXP_ROW0) && (r1 == EXP_ROW1) &&
               (r2 == EXP_ROW2) && (r3 == EXP_ROW3);
    endfunction

endpackage

// File: rtl/trainer_gate_bank.sv
// Purely combinational bank of the seven basic two-input gates.
module trainer_gate_bank
    import trainer_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [6:0] y
);

    // XOR kept as its own named net so it can be observed on its own
    logic xor_y;

    assign xor_y = a ^ b;

    always_comb begin
        y            = '0;
        y[GATE_AND]  = a & b;
        y[GATE_OR]   = a | b;
        y[GATE_NOTA] = ~a;
        y[GATE_NAND] = ~(a & b);
        y[GATE_NOR]  = ~(a | b);
        y[GATE_XOR]  = xor_y;
        y[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/trainer_sweep_ctrl.sv
// Gate trainer: manual operand drive or an automatic four-vector sweep that
// captures each gate-bank row. Optional self-check under TRAINER_SELFTEST_EN.
module trainer_sweep_ctrl
    import trainer_pkg::*;
#(
    parameter int DWELL = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       mode,
    input  logic       start,
    input  logic       man_a,
    input  logic       man_b,
    input  logic [1:0] rd_row,
    output logic [6:0] live_out,
    output logic [6:0] row_out,
    output logic [1:0] step,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [1:0] state_dbg
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    sweep_state_e state;
    logic [1:0]   idx;
    logic [7:0]   cnt;
    logic [6:0]   rows [4];
    logic         busy_q;
    logic         done_q;
    logic         apply_vec;
    logic         gate_a;
    logic         gate_b;
    logic [6:0]   gate_y;

    // Sweep operands only while actually sweeping in auto mode; a drop of
    // mode shows the manual operands at once, ahead of the abort edge.
    assign apply_vec = (state == ST_APPLY) && mode;
    assign gate_a    = apply_vec ? idx[0] : man_a;
    assign gate_b    = apply_vec ? idx[1] : man_b;

    trainer_gate_bank u_gate_bank (
        .a (gate_a),
        .b (gate_b),
        .y (gate_y)
    );

    assign live_out  = gate_y;
    assign row_out   = rows[rd_row];
    assign step      = idx;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state;

`ifdef TRAINER_SELFTEST_EN
    logic pass_q;
    logic fail_q;
    assign pass = pass_q;
    assign fail = fail_q;
`else
    assign pass = 1'b0;
    assign fail = 1'b0;
`endif

    // Request handshake: start is a level sampled on every enabled edge; it
    // is accepted only when busy is low and mode is 1, and busy rises on the
    // accepting edge. Requests seen while busy is high are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= 2'd0;
            cnt    <= 8'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 4; i++) rows[i] <= 7'd0;
`ifdef TRAINER_SELFTEST_EN
            pass_q <= 1'b0;
            fail_q <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (mode && start) begin
                        state  <= ST_APPLY;
                        idx    <= 2'd0;
                        cnt    <= 8'd0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        for (int i = 0; i < 4; i++) rows[i] <= 7'd0;
`ifdef TRAINER_SELFTEST_EN
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
`endif
                    end
                end
                ST_APPLY: begin
                    if (!mode) begin
                        state  <= ST_IDLE;
                        idx    <= 2'd0;
                        cnt    <= 8'd0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        for (int i = 0; i < 4; i++) rows[i] <= 7'd0;
`ifdef TRAINER_SELFTEST_EN
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
`endif
                    end else if (cnt == DWELL_LAST) begin
                        rows[idx] <= gate_y;
                        cnt       <= 8'd0;
                        if (idx == 2'd3) begin
                            state  <= ST_DONE;
                            idx    <= 2'd0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
`ifdef TRAINER_SELFTEST_EN
                            // Row 3 is being captured on this very edge
                            pass_q <= rows_match(rows[0], rows[1], rows[2], gate_y);
                            fail_q <= !rows_match(rows[0], rows[1], rows[2], gate_y);
`endif
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    idx    <= 2'd0;
                    cnt    <= 8'd0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
